// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline skid register stage.
// The state encoding doubles as the occupancy count (entries held).
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

endpackage

// File: rtl/pipe_dffe.sv
// Enabled data register with asynchronous active-low clear to RST_VAL.
// Holds its value whenever en is low, so in_data is never sampled unless
// the owning stage has decided to load it.
module pipe_dffe #(
    parameter int                 WIDTH   = 32,
    parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Next value: load d when enabled, otherwise hold.
    always_comb begin
        data_d = data_q;
        if (en) begin
            data_d = d;
        end
    end

    // Data flop with asynchronous clear.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            data_q <= RST_VAL;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline register stage with a one-entry skid buffer.
//
// Handshake: a beat moves on a port in any cycle where valid and ready are
// both high at the rising edge; valid, once raised by the stage, is held
// with stable data until that happens or a flush squashes it.
//
// in_ready depends only on the registered skid state and flush, so the
// downstream out_ready never forms a combinational path to the upstream.
// The state register is visible on occ (same 2-bit encoding).
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occ
);

    state_t state_q;
    state_t state_d;

    logic             main_valid;
    logic             skid_valid;
    logic             in_fire;
    logic             out_fire;
    logic             main_en;
    logic             main_from_skid;
    logic             skid_en;
    logic [WIDTH-1:0] main_data;
    logic [WIDTH-1:0] skid_data;
    logic [WIDTH-1:0] main_in;

    // Valid bits are a direct decode of the occupancy state.
    assign main_valid = (state_q != EMPTY);
    assign skid_valid = (state_q == FULL);

    assign in_ready  = !skid_valid && !flush;
    assign in_fire   = in_valid && in_ready;
    assign out_valid = main_valid;
    assign out_fire  = main_valid && out_ready;
    assign out_data  = main_data;
    assign occ       = state_q;

    // Next state and data-register load enables; flush overrides everything.
    always_comb begin
        state_d        = state_q;
        main_en        = 1'b0;
        main_from_skid = 1'b0;
        skid_en        = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        main_en = 1'b1;
                        state_d = BUSY;
                    end
                end
                BUSY: begin
                    if (in_fire && out_fire) begin
                        main_en = 1'b1;
                    end else if (in_fire) begin
                        skid_en = 1'b1;
                        state_d = FULL;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        main_en        = 1'b1;
                        main_from_skid = 1'b1;
                        state_d        = BUSY;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // Main register refills from the skid entry when draining FULL.
    assign main_in = main_from_skid ? skid_data : in_data;

    // State register with asynchronous clear.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    pipe_dffe #(
        .WIDTH   (WIDTH),
        .RST_VAL (RST_VAL)
    ) u_main (
        .clk  (clk),
        .clrn (clrn),
        .en   (main_en),
        .d    (main_in),
        .q    (main_data)
    );

    pipe_dffe #(
        .WIDTH   (WIDTH),
        .RST_VAL (RST_VAL)
    ) u_skid (
        .clk  (clk),
        .clrn (clrn),
        .en   (skid_en),
        .d    (in_data),
        .q    (skid_data)
    );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed and randomised checks for pipe_skid_reg (WIDTH=32, RST_VAL=DEADBEEF).
module tb_pipe_skid_reg;

    localparam int          W    = 32;
    localparam logic [31:0] RSTV = 32'hDEADBEEF;

    logic         clk;
    logic         clrn;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [1:0]   occ;

    int n_assert;
    int n_fail;

    logic [W-1:0] exp_q[$];

    pipe_skid_reg #(
        .WIDTH   (W),
        .RST_VAL (RSTV)
    ) dut (
        .clk       (clk),
        .clrn      (clrn),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occ       (occ)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] cnt;
        logic [W-1:0] hold_data;
        logic         hold_chk;
        logic         fin;
        logic         fout;
        logic [W-1:0] exp_v;
        int           beats;
        int           cycles;

        n_assert  = 0;
        n_fail    = 0;
        clrn      = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // Reset asserted mid-cycle, checked before any clock edge
        #3 clrn = 1'b0;
        #1;
        chk("rst_out_data", out_data, RSTV);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_occ", {30'b0, occ}, 32'd0);
        tick();
        tick();
        @(negedge clk);
        clrn = 1'b1;

        // Streaming 1..8 at full rate, first beat on the first edge after release
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_data   = 32'd1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("stream_data", out_data, i);
            chk("stream_valid", {31'b0, out_valid}, 32'd1);
            chk("stream_ready", {31'b0, in_ready}, 32'd1);
            if (i < 8) in_data = i + 1;
            else in_valid = 1'b0;
        end
        tick();
        chk("stream_drain_occ", {30'b0, occ}, 32'd0);

        // Backpressure: fill to FULL, then drain A then B
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hA;
        tick();
        chk("bp1_occ", {30'b0, occ}, 32'd1);
        chk("bp1_data", out_data, 32'hA);
        in_data = 32'hB;
        tick();
        chk("bp2_occ", {30'b0, occ}, 32'd2);
        chk("bp2_in_ready", {31'b0, in_ready}, 32'd0);
        chk("bp2_data", out_data, 32'hA);
        in_data = 32'hC;
        tick();
        chk("bp3_hold_occ", {30'b0, occ}, 32'd2);
        chk("bp3_hold_data", out_data, 32'hA);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp4_data", out_data, 32'hB);
        chk("bp4_occ", {30'b0, occ}, 32'd1);
        chk("bp4_in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        chk("bp5_occ", {30'b0, occ}, 32'd0);
        chk("bp5_valid", {31'b0, out_valid}, 32'd0);

        // Flush while FULL with a beat offered
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hA;
        tick();
        in_data = 32'hB;
        tick();
        chk("fl_pre_occ", {30'b0, occ}, 32'd2);
        flush   = 1'b1;
        in_data = 32'hC;
        #1;
        chk("fl_in_ready", {31'b0, in_ready}, 32'd0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_occ", {30'b0, occ}, 32'd0);
        chk("fl_valid", {31'b0, out_valid}, 32'd0);
        chk("fl_data_kept", out_data, 32'hA);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("fl_no_c", {31'b0, out_valid}, 32'd0);
        end

        // Flush coinciding with an out_fire in BUSY: beat is not re-sent
        in_valid = 1'b1;
        in_data  = 32'hD;
        tick();
        in_valid = 1'b0;
        chk("flb_data", out_data, 32'hD);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flb_occ", {30'b0, occ}, 32'd0);
        tick();
        chk("flb_no_resend", {31'b0, out_valid}, 32'd0);

        // Randomised traffic with an incrementing payload
        cnt      = 32'd0;
        beats    = 0;
        cycles   = 0;
        hold_chk = 1'b0;
        hold_data = '0;
        while (beats < 10000 && cycles < 60000) begin
            in_valid  = ($urandom_range(0, 1) == 1);
            out_ready = ($urandom_range(0, 1) == 1);
            in_data   = cnt;
            @(negedge clk);
            chk("rnd_occ", {30'b0, occ}, exp_q.size());
            if (hold_chk) begin
                chk("rnd_stable_valid", {31'b0, out_valid}, 32'd1);
                chk("rnd_stable_data", out_data, hold_data);
            end
            fin  = in_valid && in_ready;
            fout = out_valid && out_ready;
            if (fout) begin
                exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
                chk("rnd_data", out_data, exp_v);
                beats++;
            end
            if (fin) begin
                exp_q.push_back(cnt);
                cnt = cnt + 1;
            end
            hold_chk  = out_valid && !out_ready;
            hold_data = out_data;
            cycles++;
            tick();
        end
        chk("rnd_done_in_budget", beats, 10000);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) begin
            @(negedge clk);
            if (out_valid) begin
                exp_v = exp_q.pop_front();
                chk("rnd_drain_data", out_data, exp_v);
            end
            tick();
        end
        chk("rnd_drain_occ", {30'b0, occ}, 32'd0);
        exp_q.delete();

        // Reset while FULL with 5/6
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h5;
        tick();
        in_data = 32'h6;
        tick();
        in_valid = 1'b0;
        chk("rf_pre_occ", {30'b0, occ}, 32'd2);
        #2 clrn = 1'b0;
        #1;
        chk("rf_occ", {30'b0, occ}, 32'd0);
        chk("rf_valid", {31'b0, out_valid}, 32'd0);
        chk("rf_data", out_data, RSTV);
        chk("rf_in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        clrn      = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h7;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("rf_first_data", out_data, 32'h7);
        chk("rf_first_valid", {31'b0, out_valid}, 32'd1);
        tick();
        chk("rf_end_occ", {30'b0, occ}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
